// File: rtl/pulse_destretcher.sv
// Pulse destretcher: one strobe plus measured width per valid stretched pulse,
// glitch rejection, overrun flag and post-pulse dead time. `DESTRETCH_SYNC_EN adds a 2-FF input synchronizer.
module pulse_destretcher #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_WIDTH = 4,
    parameter int unsigned MAX_WIDTH = 200,
    parameter int unsigned HOLDOFF   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_signal,
    output logic             pulse_out,
    output logic [CNT_W-1:0] width_out,
    output logic             width_valid,
    output logic             too_long,
    output logic             busy
);

    localparam int unsigned HO_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [HO_W-1:0]  HO_LAST = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_WIDTH);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_MEASURE,
        ST_OVERRUN,
        ST_HOLDOFF
    } state_t;

    logic in_s;
    logic in_ok;

`ifdef DESTRETCH_SYNC_EN
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [1:0] prime_q, prime_d;

    always_comb begin
        sync1_d = input_signal;
        sync2_d = sync1_q;
        prime_d = {prime_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prime_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prime_q <= prime_d;
        end
    end

    // Reset zeros in the synchronizer are not real input; ARM waits until it holds sampled data.
    assign in_s  = sync2_q;
    assign in_ok = prime_q[1];
`else
    assign in_s  = input_signal;
    assign in_ok = 1'b1;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [HO_W-1:0]  hold_q, hold_d;
    logic             pulse_q, pulse_d;
    logic             valid_q, valid_d;
    logic             long_q, long_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        hold_d  = hold_q;
        pulse_d = 1'b0;
        valid_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (in_ok && !in_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (in_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (in_s) begin
                    if (cnt_q == MAX_C) begin
                        long_d  = 1'b1;
                        state_d = ST_OVERRUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q >= MIN_C) begin
                    pulse_d = 1'b1;
                    valid_d = 1'b1;
                    width_d = cnt_q;
                    hold_d  = '0;
                    state_d = ST_HOLDOFF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OVERRUN: begin
                if (!in_s) begin
                    hold_d  = '0;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == HO_LAST) state_d = ST_ARM;
                else hold_d = hold_q + HO_W'(1);
            end
            default: state_d = ST_ARM;
        endcase
        busy_d = (state_d == ST_MEASURE) || (state_d == ST_OVERRUN) || (state_d == ST_HOLDOFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            width_q <= '0;
            hold_q  <= '0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
            long_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            hold_q  <= hold_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
            long_q  <= long_d;
            busy_q  <= busy_d;
        end
    end

    assign pulse_out   = pulse_q;
    assign width_out   = width_q;
    assign width_valid = valid_q;
    assign too_long    = long_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_destretcher.sv
// Self-checking bench for pulse_destretcher: directed pulse table, hand-written
// holdoff/reset sequences, then random pulse trains against a run-length model.
module tb_pulse_destretcher;

    localparam int unsigned MIN_W = 4;
    localparam int unsigned MAX_W = 200;
    localparam int unsigned HOLD  = 8;
`ifdef DESTRETCH_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int LAT = D + 1;
    localparam int N   = 4000;
    localparam int NX  = N + 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       input_signal = 1'b0;
    logic       pulse_out;
    logic [7:0] width_out;
    logic       width_valid;
    logic       too_long;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    pulse_destretcher #(
        .CNT_W(8),
        .MIN_WIDTH(MIN_W),
        .MAX_WIDTH(MAX_W),
        .HOLDOFF(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .input_signal(input_signal),
        .pulse_out(pulse_out),
        .width_out(width_out),
        .width_valid(width_valid),
        .too_long(too_long),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned len;
        bit          acc;
        int unsigned w;
        bit          tl;
    } row_t;

    row_t rows[8];

    bit          x[NX];
    bit          e_po[NX];
    bit          e_tl[NX];
    bit          e_busy[NX];
    int unsigned e_accw[NX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v);
        input_signal = v;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        input_signal = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b0);
    endtask

    task automatic run_pulse(input int unsigned len, input int unsigned tail,
                             output int unsigned n_po, output int unsigned n_wv,
                             output int unsigned n_tl, output int po_at,
                             output int tl_at, output int unsigned busy_after);
        n_po = 0; n_wv = 0; n_tl = 0; po_at = -1; tl_at = -1; busy_after = 0;
        for (int k = 0; k < int'(len + tail); k++) begin
            step(k < int'(len));
            if (pulse_out) begin
                n_po++;
                if (po_at < 0) po_at = k - int'(len);
            end
            if (width_valid && pulse_out) n_wv++;
            if (too_long) begin
                n_tl++;
                if (tl_at < 0) tl_at = k;
            end
            if (po_at >= 0 && busy) busy_after++;
        end
    endtask

    task automatic pulse_then_second(input int unsigned delay, output int unsigned npo,
                                     output int unsigned nwv);
        int p;
        p = -1;
        for (int k = 0; k < 30; k++) step(1'b1);
        for (int k = 0; k < 10 && p < 0; k++) begin
            step(1'b0);
            if (pulse_out) p = k;
        end
        check("t4_first_latency", p, LAT - 1);
        for (int k = 1; k < int'(delay); k++) step(1'b0);
        npo = 0; nwv = 0;
        for (int k = 0; k < 60; k++) begin
            step(k < 20);
            if (pulse_out) npo++;
            if (width_valid) nwv++;
        end
    endtask

    initial begin
        int unsigned n_po, n_wv, n_tl, busy_after;
        int          po_at, tl_at;
        int unsigned pos, gap, hl, sel;
        int          i, r, s, L, hend, e, idx;
        logic [7:0]  wexp;

        rows[0] = '{101, 1'b1, 101, 1'b0};
        rows[1] = '{3,   1'b0, 101, 1'b0};
        rows[2] = '{4,   1'b1, 4,   1'b0};
        rows[3] = '{1,   1'b0, 4,   1'b0};
        rows[4] = '{200, 1'b1, 200, 1'b0};
        rows[5] = '{201, 1'b0, 200, 1'b1};
        rows[6] = '{250, 1'b0, 200, 1'b1};
        rows[7] = '{5,   1'b1, 5,   1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {pulse_out, width_valid, too_long, busy, width_out}, '0);

        apply_reset();
        for (int t = 0; t < 8; t++) begin
            run_pulse(rows[t].len, 40, n_po, n_wv, n_tl, po_at, tl_at, busy_after);
            check($sformatf("row%0d_pulse_count", t), n_po, rows[t].acc);
            check($sformatf("row%0d_valid_coincident", t), n_wv, rows[t].acc);
            check($sformatf("row%0d_width", t), width_out, rows[t].w);
            check($sformatf("row%0d_too_long_count", t), n_tl, rows[t].tl);
            if (rows[t].acc) begin
                check($sformatf("row%0d_latency", t), po_at, LAT - 1);
                check($sformatf("row%0d_holdoff_busy", t), busy_after, HOLD);
            end
            if (rows[t].tl) check($sformatf("row%0d_too_long_at", t), tl_at, MAX_W + D);
        end

        pulse_then_second(3, n_po, n_wv);
        check("t4_near_ignored_po", n_po, 0);
        check("t4_near_ignored_wv", n_wv, 0);
        check("t4_near_width", width_out, 30);
        pulse_then_second(15, n_po, n_wv);
        check("t4_far_accepted_po", n_po, 1);
        check("t4_far_width", width_out, 20);

        for (int k = 0; k < 50; k++) step(1'b1);
        check("t5_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_reset_outputs", {pulse_out, width_valid, too_long, busy, width_out}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_po = 0; n_tl = 0;
        for (int k = 0; k < 91; k++) begin
            step(k < 51);
            if (pulse_out || width_valid) n_po++;
            if (too_long) n_tl++;
        end
        check("t5_partial_no_strobe", n_po, 0);
        check("t5_partial_no_too_long", n_tl, 0);
        check("t5_width_cleared", width_out, 0);
        run_pulse(101, 40, n_po, n_wv, n_tl, po_at, tl_at, busy_after);
        check("t5_next_pulse_po", n_po, 1);
        check("t5_next_pulse_width", width_out, 101);

        // Random pulse trains; expected events derived from run lengths of the sampled input.
        pos = 0;
        while (pos < N) begin
            sel = $urandom_range(0, 9);
            gap = (sel < 4) ? $urandom_range(1, 4) : $urandom_range(5, 25);
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2: hl = $urandom_range(1, MIN_W - 1);
                3:       hl = MIN_W;
                4:       hl = MIN_W - 1;
                5:       hl = MAX_W;
                6:       hl = MAX_W + 1;
                7:       hl = $urandom_range(MAX_W + 2, MAX_W + 40);
                default: hl = $urandom_range(MIN_W + 1, 40);
            endcase
            pos += gap;
            for (int k = 0; k < int'(hl); k++) begin
                x[pos] = 1'b1;
                pos++;
            end
        end

        i = 0; r = 0;
        while (i < NX) begin
            if (x[i] && i >= r) begin
                s = i; L = 0;
                while (s + L < NX && x[s + L]) L++;
                if (L < int'(MIN_W)) begin
                    for (int k = s; k < s + L; k++) e_busy[k] = 1'b1;
                    r = s + L + 1;
                end else begin
                    if (L > int'(MAX_W)) e_tl[s + MAX_W] = 1'b1;
                    else begin
                        e_po[s + L]   = 1'b1;
                        e_accw[s + L] = L;
                    end
                    hend = s + L + ((HOLD > 0) ? HOLD : 1);
                    for (int k = s; k < hend && k < NX; k++) e_busy[k] = 1'b1;
                    e = hend;
                    while (e < NX && x[e]) e++;
                    r = e + 1;
                end
                i = s + L;
            end else begin
                i++;
            end
        end

        apply_reset();
        wexp = '0;
        for (int k = 0; k < NX + D; k++) begin
            step((k < NX) ? x[k] : 1'b0);
            idx = k - D;
            if (idx >= 0) begin
                if (e_accw[idx] != 0) wexp = 8'(e_accw[idx]);
                check($sformatf("rnd@%0d", k), {pulse_out, width_valid, too_long, busy, width_out},
                      {e_po[idx], e_po[idx], e_tl[idx], e_busy[idx], wexp});
            end else begin
                check($sformatf("rnd@%0d", k), {pulse_out, width_valid, too_long, busy, width_out},
                      {4'b0000, wexp});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
